// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core/debug memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER__CORE,
        ARB_OWNER__DEBUG
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Grant decision for one arbitration slot: debug lock, then starvation, then core priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       c_req,
    input  logic       d_req,
    input  logic       locked,
    input  logic       starve,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    always_comb begin
        grant_valid = 1'b0;
        grant_owner = ARB_OWNER__CORE;
        // A held lock shuts the core out completely, even when debug is idle.
        if (locked) begin
            grant_valid = d_req;
            grant_owner = ARB_OWNER__DEBUG;
        end else if (d_req && (!c_req || starve)) begin
            grant_valid = 1'b1;
            grant_owner = ARB_OWNER__DEBUG;
        end else if (c_req) begin
            grant_valid = 1'b1;
            grant_owner = ARB_OWNER__CORE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and debug accesses to the unified memory: IDLE (grant) -> ACCESS -> RESP.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    input  logic          d_lock,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    arb_state_t     state, next_state;
    arb_owner_t     owner, grant_owner;
    logic [WCW-1:0] wait_cnt;
    logic           locked, grant_valid, starve, lock_eff;
    logic           lat_we;
    logic [AW-1:0]  lat_addr;
    logic [DW-1:0]  lat_wdata;

    // Dropping d_lock releases the lock in the very cycle it is seen.
    assign lock_eff = locked && d_lock;
    assign starve   = (wait_cnt == WCW'(MAX_WAIT));

    arb_pick u_pick (
        .c_req       (c_req),
        .d_req       (d_req),
        .locked      (lock_eff),
        .starve      (starve),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        c_ack      = 1'b0;
        d_ack      = 1'b0;
        case (state)
            ARB_IDLE: if (grant_valid) next_state = ARB_ACCESS;
            ARB_ACCESS: begin
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                mem_we     = lat_we && !reset;
                next_state = ARB_RESP;
            end
            ARB_RESP: begin
                mem_addr   = lat_addr;
                c_ack      = (owner == ARB_OWNER__CORE) && !reset;
                d_ack      = (owner == ARB_OWNER__DEBUG) && !reset;
                next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= ARB_OWNER__CORE;
            wait_cnt  <= '0;
            locked    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (locked && !d_lock) locked <= 1'b0;
                    if (grant_valid) begin
                        owner <= grant_owner;
                        if (grant_owner == ARB_OWNER__DEBUG) begin
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            wait_cnt  <= '0;
                        end else begin
                            lat_we    <= c_we;
                            lat_addr  <= c_addr;
                            lat_wdata <= c_wdata;
                            if (d_req && !starve) wait_cnt <= wait_cnt + WCW'(1);
                        end
                    end
                end
                // Read data is captured for writes too: it is the pre-write contents.
                ARB_ACCESS: begin
                    if (owner == ARB_OWNER__CORE) c_rdata <= mem_rdata;
                    else                          d_rdata <= mem_rdata;
                end
                ARB_RESP: if (owner == ARB_OWNER__DEBUG) locked <= d_lock;
                default: ;
            endcase
        end
    end

    assign core_stall = c_req && !c_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32, DW = 32, MAX_WAIT = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic [DW-1:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          c_ack, d_ack, mem_we, core_stall;

    int checks = 0, failures = 0;
    bit started = 0;
    int we_cnt = 0, ack_cnt = 0;
    int ack_log[$];  // 0 = core ack, 1 = debug ack

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_lock(d_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .core_stall(core_stall)
    );

    always #5 clk = ~clk;

    // Memory macro: combinational read, write on the clock edge.
    logic [DW-1:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h100] = 32'hDEADBEEF;
        mem[10'h080] = 32'hAAAA0000;
    end
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = free, 1 = memory slot, 2 = response slot.
    int            m_phase = 0, m_wait = 0;
    bit            m_locked = 0, m_dbg = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_crd = '0, m_drd = '0;
    bit            m_crd_ok = 0, m_drd_ok = 0;

    // Who wins a free slot: 0 nobody, 1 core, 2 debug.
    function automatic int policy(bit cr, bit dr, bit lk, int w);
        if (lk) return dr ? 2 : 0;
        if (dr && (!cr || w >= MAX_WAIT)) return 2;
        return cr ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase  <= 0;
            m_wait   <= 0;
            m_locked <= 0;
            m_crd_ok <= 0;
            m_drd_ok <= 0;
        end else if (m_phase == 0) begin
            int g;
            g = policy(c_req, d_req, m_locked && d_lock, m_wait);
            if (!d_lock) m_locked <= 0;
            if (g == 2) begin
                m_dbg <= 1; m_we <= d_we; m_addr <= d_addr; m_wdata <= d_wdata;
                m_wait <= 0; m_phase <= 1;
            end else if (g == 1) begin
                m_dbg <= 0; m_we <= c_we; m_addr <= c_addr; m_wdata <= c_wdata;
                if (d_req) m_wait <= (m_wait >= MAX_WAIT) ? MAX_WAIT : m_wait + 1;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (m_dbg) begin m_drd <= mem[m_addr[9:0]]; m_drd_ok <= 1; end
            else       begin m_crd <= mem[m_addr[9:0]]; m_crd_ok <= 1; end
            m_phase <= 2;
        end else begin
            if (m_dbg) m_locked <= d_lock;
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit e_cack, e_dack;
            e_cack = (m_phase == 2) && !m_dbg && !reset;
            e_dack = (m_phase == 2) && m_dbg && !reset;
            chk("mem_we", mem_we, (m_phase == 1) && m_we && !reset);
            chk("c_ack", c_ack, e_cack);
            chk("d_ack", d_ack, e_dack);
            chk("core_stall", core_stall, c_req && !e_cack);
            if (m_phase == 0) chk("mem_addr_idle", mem_addr, 0);
            if (m_phase == 1) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_crd_ok) chk("c_rdata", c_rdata, m_crd);
            if (m_drd_ok) chk("d_rdata", d_rdata, m_drd);
            if (c_ack) ack_log.push_back(0);
            if (d_ack) ack_log.push_back(1);
            if (c_ack || d_ack) ack_cnt++;
            if (mem_we) we_cnt++;
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(int n, int budget, string name);
        int k = 0;
        while (ack_log.size() < n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        if (ack_log.size() < n) begin
            checks++; failures++;
            $display("FAIL %s timeout acks=%0d expected=%0d", name, ack_log.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        reset = 1'b0;
        started = 1;
        @(negedge clk);
        chk("rst_c_ack", c_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_state", dut.state, ARB_IDLE);

        // Core-only read of 0x100; address changed after grant must be ignored.
        cyc(); c_req = 1; c_addr = 32'h100; c_we = 0;
        @(negedge clk); chk("t1_stall0", core_stall, 1);
        cyc(); c_addr = 32'h200;
        @(negedge clk); chk("t1_addr", mem_addr, 32'h100); chk("t1_stall1", core_stall, 1);
        cyc();
        @(negedge clk); chk("t1_ack", c_ack, 1); chk("t1_rdata", c_rdata, 32'hDEADBEEF);
        cyc(); c_req = 0;

        // Debug write 0x40, then core read back.
        cyc(); ack_log.delete(); we_cnt = 0;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
        wait_log(1, 10, "t2_dwr");
        cyc(); d_req = 0; d_we = 0;
        cyc(2);
        chk("t2_we_pulses", we_cnt, 1);
        ack_log.delete(); c_req = 1; c_addr = 32'h40;
        wait_log(1, 10, "t2_crd");
        chk("t2_readback", c_rdata, 32'h12345678);
        cyc(); c_req = 0;

        // Anti-starvation: both held, core wins MAX_WAIT times then debug.
        cyc(); ack_log.delete();
        c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h20; d_we = 0;
        wait_log(5, 60, "t3_acks");
        cyc(); c_req = 0; d_req = 0;
        for (int i = 0; i < 5; i++) if (i < ack_log.size()) chk("t3_order", ack_log[i], (i == 4) ? 1 : 0);
        chk("t3_wait_cnt", dut.wait_cnt, 0);

        // Lock: debug keeps the bus until d_lock drops, then core goes next.
        cyc(); ack_log.delete();
        d_req = 1; d_lock = 1; d_addr = 32'h40;
        cyc(); c_req = 1; c_addr = 32'h10;
        wait_log(4, 40, "t4_locked");
        cyc(); d_lock = 0;
        wait_log(5, 20, "t4_release");
        cyc(); c_req = 0; d_req = 0;
        for (int i = 0; i < 5; i++) if (i < ack_log.size()) chk("t4_order", ack_log[i], (i == 4) ? 0 : 1);

        // Reset during the ACCESS cycle of a core write to 0x80.
        cyc(); c_req = 1; c_we = 1; c_addr = 32'h80; c_wdata = 32'h55555555;
        cyc(); reset = 1; c_req = 0; c_we = 0;
        @(negedge clk); chk("t5_in_access", dut.state, ARB_ACCESS); chk("t5_we_blocked", mem_we, 0);
        cyc(); reset = 0;
        @(negedge clk);
        chk("t5_state", dut.state, ARB_IDLE);
        chk("t5_c_ack", c_ack, 0);
        chk("t5_d_ack", d_ack, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_kept", mem[10'h080], 32'hAAAA0000);

        // Idle for 10 cycles.
        we_cnt = 0; ack_cnt = 0;
        cyc(10);
        chk("t6_we", we_cnt, 0);
        chk("t6_acks", ack_cnt, 0);
        chk("t6_wait_cnt", dut.wait_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
